// File: rtl/basys_hex_entry.sv
// Front-panel hex entry: synchronises and debounces three buttons, assembles switch nibbles
// into a value, and hands the value to the processor side over a valid/ready handshake.
module basys_hex_entry #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int NUM_DIGITS      = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [3:0]              sw,
  input  logic                    btn_enter,
  input  logic                    btn_clear,
  input  logic                    btn_submit,
  output logic [4*NUM_DIGITS-1:0] value_out,
  output logic                    value_valid,
  input  logic                    value_ready,
  output logic [4*NUM_DIGITS-1:0] preview,
  output logic [2:0]              digit_count,
  output logic                    busy
);

  localparam int             W          = 4 * NUM_DIGITS;
  localparam int             CW         = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST   = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [2:0]     MAX_DIGITS = 3'(NUM_DIGITS);

  typedef enum logic {ENTRY, HOLD} state_t;

  logic [2:0] btn_raw;
  logic [2:0] btn_s1_reg, btn_s2_reg;
  logic [3:0] sw_s1_reg, sw_s2_reg;
  logic [2:0] press;

  // Bit order: 0 = enter, 1 = clear, 2 = submit
  assign btn_raw = {btn_submit, btn_clear, btn_enter};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      btn_s1_reg <= '0;
      btn_s2_reg <= '0;
      sw_s1_reg  <= '0;
      sw_s2_reg  <= '0;
    end else begin
      btn_s1_reg <= btn_raw;
      btn_s2_reg <= btn_s1_reg;
      sw_s1_reg  <= sw;
      sw_s2_reg  <= sw_s1_reg;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_db
      logic [CW-1:0] cnt_reg;
      logic          db_reg;
      logic          pulse_reg;

      // Pulse fires on the same edge the debounced level rises; falls are silent
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          cnt_reg   <= '0;
          db_reg    <= 1'b0;
          pulse_reg <= 1'b0;
        end else if (btn_s2_reg[gi] == db_reg) begin
          cnt_reg   <= '0;
          pulse_reg <= 1'b0;
        end else if (cnt_reg == CNT_LAST) begin
          cnt_reg   <= '0;
          db_reg    <= ~db_reg;
          pulse_reg <= ~db_reg;
        end else begin
          cnt_reg   <= cnt_reg + 1'b1;
          pulse_reg <= 1'b0;
        end
      end

      assign press[gi] = pulse_reg;
    end
  endgenerate

  state_t       state_reg, state_next;
  logic [W-1:0] preview_reg, preview_next;
  logic [W-1:0] value_reg, value_next;
  logic [2:0]   count_reg, count_next;
  logic         valid_reg, valid_next;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= ENTRY;
      preview_reg <= '0;
      value_reg   <= '0;
      count_reg   <= '0;
      valid_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      preview_reg <= preview_next;
      value_reg   <= value_next;
      count_reg   <= count_next;
      valid_reg   <= valid_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    preview_next = preview_reg;
    value_next   = value_reg;
    count_next   = count_reg;
    valid_next   = valid_reg;
    case (state_reg)
      ENTRY: begin
        if (press[1]) begin
          preview_next = '0;
          count_next   = '0;
        end else if (press[2] && count_reg != 3'd0) begin
          value_next   = preview_reg;
          valid_next   = 1'b1;
          preview_next = '0;
          count_next   = '0;
          state_next   = HOLD;
        end else if (press[0] && count_reg < MAX_DIGITS) begin
          preview_next = {preview_reg[W-5:0], sw_s2_reg};
          count_next   = count_reg + 3'd1;
        end
      end
      HOLD: begin
        // Presses in HOLD are dropped; only the consumer can release us
        if (value_ready) begin
          valid_next = 1'b0;
          state_next = ENTRY;
        end
      end
      default: state_next = ENTRY;
    endcase
  end

  assign value_out   = value_reg;
  assign value_valid = valid_reg;
  assign preview     = preview_reg;
  assign digit_count = count_reg;
  assign busy        = (state_reg == HOLD);

endmodule

// File: doc/basys_hex_entry.md
Name: basys_hex_entry

Overview:
- Board-input reader for the Basys front panel. It is the input-side counterpart of the 7-segment output path.
- Synchronises and debounces three pushbuttons and takes a nibble from the slide switches on each ENTER press. Up to NUM_DIGITS nibbles are assembled into a hex value, which is offered to the processor side over a valid/ready handshake.
- A live preview of the value being assembled is exported so the display path can show digits as they are keyed.

Parameters:
- DEBOUNCE_CYCLES, 1000000: cycles a synchronised button level must differ from the debounced level before the debounced level flips (10 ms at 100 MHz). Legal range 2 to 2^24-1.
- NUM_DIGITS, 4: maximum nibbles per value. value_out width is 4*NUM_DIGITS.

Ports:
- clk  in  1  system clock, all state rises on posedge.
- reset_n  in  1  asynchronous active-low reset.
- sw  in  4  slide switches, nibble to enter. Asynchronous to clk.
- btn_enter  in  1  raw pushbutton: append sw as the least significant nibble.
- btn_clear  in  1  raw pushbutton: discard the partial entry.
- btn_submit  in  1  raw pushbutton: offer the assembled value.
- value_out  out  4*NUM_DIGITS  submitted value, stable while value_valid=1.
- value_valid  out  1  submitted value is available.
- value_ready  in  1  consumer accepts value_out on a cycle where value_valid=1.
- preview  out  4*NUM_DIGITS  accumulator contents, for display.
- digit_count  out  3  nibbles entered so far, range 0..NUM_DIGITS.
- busy  out  1  high in HOLD state.

Behaviour:
- Reset (async assert, release sync to clk): value_out=0, value_valid=0, preview=0, digit_count=0, busy=0.
  - Also cleared by reset: all synchroniser flops, debounced levels, debounce counters and pulse flags. State=ENTRY.
- Synchronisers:
  - Each button and each sw bit passes through two flops (s1, s2).
  - sw is used only through its s2 copy.
- Debounce, per button:
  - If s2 equals the debounced level db, counter cleared to 0.
  - Otherwise, if counter equals DEBOUNCE_CYCLES-1: db flips and counter clears. Otherwise counter increments.
  - A press pulse is registered on the same edge that db flips 0->1. It is high for exactly one cycle. Release (1->0) produces no pulse.
  - Latency: raw input high before edge 1 and held → db=1 and pulse high after edge DEBOUNCE_CYCLES+2 → accumulator effect at edge DEBOUNCE_CYCLES+3.
  - A glitch shorter than DEBOUNCE_CYCLES cycles produces no pulse.
- FSM ENTRY, with priority per cycle clear > submit > enter:
  - clear pulse: preview=0, digit_count=0.
  - submit pulse with digit_count>0: value_out<=preview, value_valid<=1, preview=0, digit_count=0, go to HOLD.
  - submit pulse with digit_count=0: ignored.
  - enter pulse with digit_count<NUM_DIGITS: preview<={preview shifted left 4, sw_s2}, digit_count+1.
  - enter pulse with digit_count=NUM_DIGITS: ignored (saturate, no wrap, no overflow).
- FSM HOLD:
  - busy=1, value_valid=1, value_out held.
  - All button pulses are ignored and discarded, not queued.
  - Handshake: when value_valid and value_ready on a clock edge: value_valid<=0, go to ENTRY on that edge. value_out retains its last value.
  - value_ready while not in HOLD has no effect.
- Reset mid-HOLD or mid-debounce: everything returns to reset values, and any in-progress press is lost.
- A button held down continuously produces a single pulse. A new pulse requires a debounced release followed by a debounced press.

Test Plan (DEBOUNCE_CYCLES=4, NUM_DIGITS=4):
- Single press: btn_enter high at edge 1 with sw=4'hA → pulse high only in the cycle after edge 6. preview=16'h000A and digit_count=1 after edge 7.
- Glitch rejection: btn_enter high for 3 cycles then low → no pulse, preview unchanged. Button bouncing 1-0-1 within 3 cycles then steady → exactly one entry.
- Saturation: enter sw=1,2,3,4,5 (separate presses) → preview=16'h1234, digit_count=4, fifth press ignored.
- Submit handshake: after 16'h1234, press submit with value_ready=0 → value_valid=1, value_out=16'h1234, busy=1. An enter press during HOLD is ignored. Raise value_ready for one cycle → value_valid=0, busy=0, preview=0.
- Priority and empty submit: clear and enter pulses forced in the same cycle → preview=0, digit_count=0. Submit with digit_count=0 → value_valid stays 0.
- Async reset: assert reset_n=0 in HOLD between clock edges → value_valid, busy, preview and digit_count go to 0 immediately, without waiting for a clock edge. After release, a new entry proceeds normally.
